// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment result display:
// converter FSM states, one-hot digit enables and the segment lookup.
package seg7_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    localparam logic [2:0] DIG_ONES  = 3'b001;
    localparam logic [2:0] DIG_TENS  = 3'b010;
    localparam logic [2:0] DIG_HUNDS = 3'b100;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to 3 BCD digits, one bit per clock.
// hex_mode bypasses the conversion and finishes after a single busy cycle.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hex_mode,
    input  logic [7:0]  bin_in,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd_out
);

    state_t      state, state_next;
    logic [7:0]  bin_q;
    logic [11:0] bcd_q;
    logic [2:0]  bit_cnt;
    logic        hex_q;
    logic [11:0] bcd_adj;
    logic [19:0] shifted;
    logic        last;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    assign last = (state == CONVERT) && (hex_q || (bit_cnt == 3'd7));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start on the final cycle chains straight into the next conversion.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONVERT;
            CONVERT: if (last && !start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == CONVERT);
        done    = last;
        bcd_out = hex_q ? {4'h0, bin_q} : shifted[19:8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            bit_cnt <= '0;
            hex_q   <= 1'b0;
        end else if (start && ((state == IDLE) || last)) begin
            bin_q   <= bin_in;
            bcd_q   <= '0;
            bit_cnt <= '0;
            hex_q   <= hex_mode;
        end else if (state == CONVERT) begin
            bcd_q   <= shifted[19:8];
            bin_q   <= shifted[7:0];
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/seg7_result_display.sv
// Captures ALU results, converts them to BCD and multiplexes three digits onto one
// segment bus. Define SEG7_HEX_MODE_EN to add the hex_mode_in port and hex display.
module seg7_result_display
    import seg7_pkg::*;
#(
    parameter logic [15:0] DIGIT_PERIOD = 16'd10_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value_in,
    input  logic       zero_in,
`ifdef SEG7_HEX_MODE_EN
    input  logic       hex_mode_in,
`endif
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic [2:0] digit_sel
);

    logic        in_hex;
    logic        eng_busy;
    logic        eng_done;
    logic [11:0] eng_bcd;
    logic        accept;
    logic        start;
    logic [7:0]  start_value;
    logic        start_zero;
    logic        start_hex;

    logic        pend_valid;
    logic [7:0]  pend_value;
    logic        pend_zero;
    logic        pend_hex;
    logic        conv_zero;
    logic        conv_hex;

    logic [3:0]  disp_ones;
    logic [3:0]  disp_tens;
    logic [3:0]  disp_hunds;
    logic        disp_zero;
    logic        disp_hex;

    logic [15:0] refresh_cnt;
    logic [2:0]  cur_dig;
    logic [3:0]  nibble;
    logic        blank;
    logic [6:0]  seg_next;

`ifdef SEG7_HEX_MODE_EN
    assign in_hex = hex_mode_in;
`else
    assign in_hex = 1'b0;
`endif

    // A direct load always beats the pending slot, so a slot hit by a later load is dropped.
    assign accept      = !eng_busy || eng_done;
    assign start       = accept && (load || pend_valid);
    assign start_value = load ? value_in : pend_value;
    assign start_zero  = load ? zero_in  : pend_zero;
    assign start_hex   = load ? in_hex   : pend_hex;

    bin2bcd_seq u_bin2bcd (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .hex_mode (start_hex),
        .bin_in   (start_value),
        .busy     (eng_busy),
        .done     (eng_done),
        .bcd_out  (eng_bcd)
    );

    assign busy = eng_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_value <= '0;
            pend_zero  <= 1'b0;
            pend_hex   <= 1'b0;
        end else if (load && !accept) begin
            pend_valid <= 1'b1;
            pend_value <= value_in;
            pend_zero  <= zero_in;
            pend_hex   <= in_hex;
        end else if (accept) begin
            pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conv_zero  <= 1'b0;
            conv_hex   <= 1'b0;
            disp_ones  <= '0;
            disp_tens  <= '0;
            disp_hunds <= '0;
            disp_zero  <= 1'b0;
            disp_hex   <= 1'b0;
        end else begin
            if (start) begin
                conv_zero <= start_zero;
                conv_hex  <= start_hex;
            end
            if (eng_done) begin
                disp_hunds <= eng_bcd[11:8];
                disp_tens  <= eng_bcd[7:4];
                disp_ones  <= eng_bcd[3:0];
                disp_zero  <= conv_zero;
                disp_hex   <= conv_hex;
            end
        end
    end

    always_comb begin
        nibble = disp_ones;
        blank  = 1'b0;
        case (cur_dig)
            DIG_TENS: begin
                nibble = disp_tens;
                blank  = !disp_hex && (disp_hunds == 4'd0) && (disp_tens == 4'd0);
            end
            DIG_HUNDS: begin
                nibble = disp_hunds;
                blank  = disp_hex || (disp_hunds == 4'd0);
            end
            default: ;
        endcase
        seg_next = blank ? SEG_BLANK : seg7_decode(nibble);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            cur_dig     <= DIG_ONES;
            digit_sel   <= '0;
            seg_out     <= SEG_BLANK;
            dp_out      <= 1'b0;
        end else begin
            digit_sel <= cur_dig;
            seg_out   <= seg_next;
            dp_out    <= (cur_dig == DIG_ONES) && disp_zero;
            if (refresh_cnt == DIGIT_PERIOD - 16'd1) begin
                refresh_cnt <= '0;
                case (cur_dig)
                    DIG_ONES: cur_dig <= DIG_TENS;
                    DIG_TENS: cur_dig <= DIG_HUNDS;
                    default:  cur_dig <= DIG_ONES;
                endcase
            end else begin
                refresh_cnt <= refresh_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_result_display.sv
// Directed bench for seg7_result_display with DIGIT_PERIOD=4.
module tb_seg7_result_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] value_in;
    logic       zero_in;
    logic       load;
    logic       busy;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [2:0] digit_sel;
`ifdef SEG7_HEX_MODE_EN
    logic       hex_mode_in;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg7_result_display #(.DIGIT_PERIOD(16'd4)) dut (
        .clk       (clk),
        .reset     (reset),
        .value_in  (value_in),
        .zero_in   (zero_in),
`ifdef SEG7_HEX_MODE_EN
        .hex_mode_in (hex_mode_in),
`endif
        .load      (load),
        .busy      (busy),
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .digit_sel (digit_sel)
    );

    typedef struct {
        logic [7:0] value;
        logic       zero;
        int         ones;
        int         tens;
        int         hunds;
        int         dp;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] v, input logic z);
        value_in = v;
        zero_in  = z;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 64) begin
            n++;
            tick();
        end
    endtask

    // Records the latest segment/dp value seen for each digit; -1 means never seen.
    task automatic observe(output int s1, output int s10, output int s100,
                           output int d1, output int d10, output int d100);
        s1 = -1; s10 = -1; s100 = -1; d1 = -1; d10 = -1; d100 = -1;
        tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            case (digit_sel)
                3'b001: begin s1 = int'(seg_out); d1 = int'(dp_out); end
                3'b010: begin s10 = int'(seg_out); d10 = int'(dp_out); end
                3'b100: begin s100 = int'(seg_out); d100 = int'(dp_out); end
                default: ;
            endcase
        end
    endtask

    task automatic sync_ones();
        int n;
        logic [2:0] prev;
        n = 0;
        prev = digit_sel;
        tick();
        while (!(digit_sel == 3'b001 && prev != 3'b001) && n < 30) begin
            prev = digit_sel;
            tick();
            n++;
        end
        check("sync_ones_timeout", int'(n >= 30), 0);
    endtask

    // Load v0, then v1 at sample ja and v2 at sample jb (sample j = cycle N+j).
    task automatic run_seq(input logic [7:0] v0, input int ja, input logic [7:0] va,
                           input int jb, input logic [7:0] vb,
                           output int bcnt, output int drop, output int seen7, output int seen42);
        bcnt = 0; drop = -1; seen7 = 0; seen42 = 0;
        do_load(v0, 1'b0);
        for (int j = 1; j <= 24; j++) begin
            if (busy) bcnt++;
            else if (drop < 0) drop = j;
            if (digit_sel == 3'b001 && seg_out == 7'h07) seen7 = 1;
            if (digit_sel == 3'b010 && seg_out == 7'h66) seen42 = 1;
            load = 1'b0;
            if (j == ja) begin value_in = va; load = 1'b1; end
            if (j == jb) begin value_in = vb; load = 1'b1; end
            tick();
        end
        load = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s1, s10, s100, d1, d10, d100;
        int n, drop, seen7, seen42;

        vecs[0] = '{8'd255, 1'b0, 'h6D, 'h6D, 'h5B, 0};
        vecs[1] = '{8'd0,   1'b1, 'h3F, 'h00, 'h00, 1};
        vecs[2] = '{8'd5,   1'b0, 'h6D, 'h00, 'h00, 0};
        vecs[3] = '{8'd10,  1'b0, 'h3F, 'h06, 'h00, 0};
        vecs[4] = '{8'd99,  1'b1, 'h6F, 'h6F, 'h00, 1};
        vecs[5] = '{8'd128, 1'b0, 'h7F, 'h5B, 'h06, 0};
        vecs[6] = '{8'd205, 1'b0, 'h6D, 'h3F, 'h5B, 0};

        reset = 1'b1; load = 1'b0; value_in = '0; zero_in = 1'b0;
`ifdef SEG7_HEX_MODE_EN
        hex_mode_in = 1'b0;
`endif
        repeat (3) tick();
        check("reset_busy", int'(busy), 0);
        check("reset_seg", int'(seg_out), 0);
        check("reset_dp", int'(dp_out), 0);
        check("reset_digit_sel", int'(digit_sel), 0);

        // Idle multiplex: 4 cycles per digit, only "0" on ones.
        reset = 1'b0;
        tick();
        for (int i = 0; i < 12; i++) begin
            check($sformatf("idle_sel_%0d", i), int'(digit_sel), (i < 4) ? 1 : (i < 8) ? 2 : 4);
            check($sformatf("idle_seg_%0d", i), int'(seg_out), (i < 4) ? 'h3F : 'h00);
            check($sformatf("idle_dp_%0d", i), int'(dp_out), 0);
            check($sformatf("idle_busy_%0d", i), int'(busy), 0);
            tick();
        end

        for (int k = 0; k < 7; k++) begin
            do_load(vecs[k].value, vecs[k].zero);
            count_busy(n);
            check($sformatf("v%0d_busy_cycles", k), n, 8);
            observe(s1, s10, s100, d1, d10, d100);
            check($sformatf("v%0d_ones", k), s1, vecs[k].ones);
            check($sformatf("v%0d_tens", k), s10, vecs[k].tens);
            check($sformatf("v%0d_hunds", k), s100, vecs[k].hunds);
            check($sformatf("v%0d_dp_ones", k), d1, vecs[k].dp);
            check($sformatf("v%0d_dp_tens", k), d10, 0);
            check($sformatf("v%0d_dp_hunds", k), d100, 0);
        end

        // 7 then pending 42 overwritten by 100: chained conversions, 42 never shown.
        sync_ones();
        run_seq(8'd7, 2, 8'd42, 5, 8'd100, n, drop, seen7, seen42);
        check("pend_busy_cycles", n, 16);
        check("pend_busy_drop", drop, 17);
        check("pend_seen7", seen7, 1);
        check("pend_seen42", seen42, 0);
        observe(s1, s10, s100, d1, d10, d100);
        check("pend_ones", s1, 'h3F);
        check("pend_tens", s10, 'h3F);
        check("pend_hunds", s100, 'h06);

        // Load in the completion cycle beats the slot holding 42.
        run_seq(8'd7, 3, 8'd42, 8, 8'd123, n, drop, seen7, seen42);
        check("beat_busy_cycles", n, 16);
        check("beat_busy_drop", drop, 17);
        check("beat_seen42", seen42, 0);
        observe(s1, s10, s100, d1, d10, d100);
        check("beat_ones", s1, 'h4F);
        check("beat_tens", s10, 'h5B);
        check("beat_hunds", s100, 'h06);

        // Reset on the 4th busy cycle aborts the conversion.
        do_load(8'd200, 1'b0);
        tick(); tick(); tick();
        check("abort_busy_before", int'(busy), 1);
        reset = 1'b1;
        tick();
        check("abort_busy", int'(busy), 0);
        check("abort_seg", int'(seg_out), 0);
        check("abort_dp", int'(dp_out), 0);
        check("abort_digit_sel", int'(digit_sel), 0);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) n++;
            tick();
        end
        check("abort_no_busy", n, 0);
        observe(s1, s10, s100, d1, d10, d100);
        check("abort_ones", s1, 'h3F);
        check("abort_tens", s10, 'h00);
        check("abort_hunds", s100, 'h00);
        check("abort_dp_ones", d1, 0);

`ifdef SEG7_HEX_MODE_EN
        hex_mode_in = 1'b1;
        do_load(8'hAF, 1'b0);
        count_busy(n);
        check("hex_af_busy", n, 1);
        observe(s1, s10, s100, d1, d10, d100);
        check("hex_af_ones", s1, 'h71);
        check("hex_af_tens", s10, 'h77);
        check("hex_af_hunds", s100, 'h00);
        do_load(8'h05, 1'b0);
        count_busy(n);
        check("hex_05_busy", n, 1);
        observe(s1, s10, s100, d1, d10, d100);
        check("hex_05_ones", s1, 'h6D);
        check("hex_05_tens", s10, 'h3F);
        check("hex_05_hunds", s100, 'h00);
        hex_mode_in = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
